// File: rtl/array_drv_pkg.sv
// ============================================================================
// Module      : array_drv_pkg
// Description : Shared FSM state encoding, default dimensions and sizing
//               helpers for the array frame driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package array_drv_pkg;

    typedef enum logic [2:0] {
        LOAD_R1 = 3'd0,
        LOAD_R2 = 3'd1,
        LOAD_R4 = 3'd2,
        COMMIT  = 3'd3,
        DRAIN   = 3'd4
    } drv_state_e;

    localparam int DEF_LANES = 4;
    localparam int DEF_EW    = 2;
    localparam int DEF_ROWS  = 5;
    localparam int DEF_COLS  = 6;
    localparam int DEF_P0    = 2;
    localparam int DEF_P1    = 4;
    localparam int DEF_P2    = 3;

    function automatic int beat_total(input int lanes, input int rows, input int cols,
                                      input int p0, input int p1);
        return lanes + rows * cols + p0 * p1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width that still works for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/array_drv_beat_ctr.sv
// ============================================================================
// Module      : array_drv_beat_ctr
// Description : Field-local beat index with field/frame-final flags and
//               row/col and p0/p1 decode for the shadow write enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_drv_beat_ctr
    import array_drv_pkg::*;
#(
    parameter  int LANES  = DEF_LANES,
    parameter  int ROWS   = DEF_ROWS,
    parameter  int COLS   = DEF_COLS,
    parameter  int P0     = DEF_P0,
    parameter  int P1     = DEF_P1,
    localparam int LANE_W = idx_w(LANES),
    localparam int ROW_W  = idx_w(ROWS),
    localparam int COL_W  = idx_w(COLS),
    localparam int P0_W   = idx_w(P0),
    localparam int P1_W   = idx_w(P1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  drv_state_e        state,
    output logic              field_final,
    output logic              frame_final,
    output logic [LANE_W-1:0] lane,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [P0_W-1:0]   p0,
    output logic [P1_W-1:0]   p1
);

    localparam int IDX_W = idx_w(max2(LANES, max2(ROWS * COLS, P0 * P1)));
    localparam int MIN_W = idx_w(max2(COLS, P1));
    localparam int MAJ_W = idx_w(max2(ROWS, P0));

    logic [IDX_W-1:0] idx_q, idx_d, last_idx;
    logic [MIN_W-1:0] minor_q, minor_d, last_minor;
    logic [MAJ_W-1:0] major_q, major_d;
    logic             in_load;

    always_comb begin
        last_idx   = '0;
        last_minor = '0;
        in_load    = 1'b1;
        case (state)
            LOAD_R1: last_idx = IDX_W'(LANES - 1);
            LOAD_R2: begin
                last_idx   = IDX_W'(ROWS * COLS - 1);
                last_minor = MIN_W'(COLS - 1);
            end
            LOAD_R4: begin
                last_idx   = IDX_W'(P0 * P1 - 1);
                last_minor = MIN_W'(P1 - 1);
            end
            default: in_load = 1'b0;
        endcase
    end

    assign field_final = in_load && (idx_q == last_idx);
    assign frame_final = field_final && (state == LOAD_R4);

    // minor is the fastest-moving coordinate (col / p1); R1 only needs idx.
    always_comb begin
        idx_d   = idx_q;
        minor_d = minor_q;
        major_d = major_q;
        if (clr || (adv && field_final)) begin
            idx_d   = '0;
            minor_d = '0;
            major_d = '0;
        end else if (adv) begin
            idx_d = idx_q + IDX_W'(1);
            if (state != LOAD_R1) begin
                if (minor_q == last_minor) begin
                    minor_d = '0;
                    major_d = major_q + MAJ_W'(1);
                end else begin
                    minor_d = minor_q + MIN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            minor_q <= '0;
            major_q <= '0;
        end else begin
            idx_q   <= idx_d;
            minor_q <= minor_d;
            major_q <= major_d;
        end
    end

    assign lane = idx_q[LANE_W-1:0];
    assign row  = major_q[ROW_W-1:0];
    assign col  = minor_q[COL_W-1:0];
    assign p0   = major_q[P0_W-1:0];
    assign p1   = minor_q[P1_W-1:0];

endmodule

`default_nettype wire

// File: rtl/array_frame_driver.sv
// ============================================================================
// Module      : array_frame_driver
// Description : Assembles a serial beat stream into shadow registers and
//               commits whole frames atomically to array outputs.
//               Optional beat parity check: define ARRAY_DRV_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_frame_driver
    import array_drv_pkg::*;
#(
    parameter  int LANES = DEF_LANES,
    parameter  int EW    = DEF_EW,
    parameter  int ROWS  = DEF_ROWS,
    parameter  int COLS  = DEF_COLS,
    parameter  int P0    = DEF_P0,
    parameter  int P1    = DEF_P1,
    parameter  int P2    = DEF_P2,
    localparam int DW    = max2(EW, P2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DW-1:0]                 wr_data,
    input  logic                          wr_last,
`ifdef ARRAY_DRV_PARITY_EN
    input  logic                          wr_par,
`endif
    output logic [EW-1:0]                 reg1 [LANES],
    output logic                          reg2 [ROWS][COLS],
    output logic [P0-1:0][P1-1:0][P2-1:0] reg4,
    output logic                          upd,
    output logic                          frame_err,
    output logic [15:0]                   frame_cnt
);

    localparam int LANE_W = idx_w(LANES);
    localparam int ROW_W  = idx_w(ROWS);
    localparam int COL_W  = idx_w(COLS);
    localparam int P0_W   = idx_w(P0);
    localparam int P1_W   = idx_w(P1);

    drv_state_e  state_q, state_d;
    logic        bad_q, bad_d;
    logic        upd_q, upd_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        commit, accept, in_load, par_bad, bad_now;
    logic        ctr_clr, ctr_adv, field_final, frame_final;

    logic [LANE_W-1:0] lane;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [P0_W-1:0]   p0;
    logic [P1_W-1:0]   p1;

    logic [EW-1:0]                 sh1_q [LANES];
    logic [EW-1:0]                 sh1_d [LANES];
    logic                          sh2_q [ROWS][COLS];
    logic                          sh2_d [ROWS][COLS];
    logic [P0-1:0][P1-1:0][P2-1:0] sh4_q, sh4_d;
    logic [EW-1:0]                 reg1_q [LANES];
    logic [EW-1:0]                 reg1_d [LANES];
    logic                          reg2_q [ROWS][COLS];
    logic                          reg2_d [ROWS][COLS];
    logic [P0-1:0][P1-1:0][P2-1:0] reg4_q, reg4_d;

`ifdef ARRAY_DRV_PARITY_EN
    assign par_bad = wr_par ^ (^wr_data);
`else
    assign par_bad = 1'b0;
`endif

    assign wr_ready = (state_q != COMMIT);
    assign accept   = wr_valid && wr_ready;
    assign in_load  = (state_q == LOAD_R1) || (state_q == LOAD_R2) || (state_q == LOAD_R4);
    assign ctr_adv  = accept && in_load;
    assign bad_now  = bad_q || par_bad;

    array_drv_beat_ctr #(
        .LANES (LANES),
        .ROWS  (ROWS),
        .COLS  (COLS),
        .P0    (P0),
        .P1    (P1)
    ) u_beat_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (ctr_clr),
        .adv         (ctr_adv),
        .state       (state_q),
        .field_final (field_final),
        .frame_final (frame_final),
        .lane        (lane),
        .row         (row),
        .col         (col),
        .p0          (p0),
        .p1          (p1)
    );

    // A parity-flagged frame is only judged at its last beat, so a bad beat
    // mid-frame keeps loading (and draining, if last goes missing).
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        ctr_clr = 1'b0;
        commit  = 1'b0;
        case (state_q)
            LOAD_R1, LOAD_R2, LOAD_R4: begin
                if (accept) begin
                    if (frame_final) begin
                        bad_d = 1'b0;
                        if (wr_last && !bad_now) begin
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = wr_last ? LOAD_R1 : DRAIN;
                        end
                    end else if (wr_last) begin
                        bad_d   = 1'b0;
                        err_d   = 1'b1;
                        ctr_clr = 1'b1;
                        state_d = LOAD_R1;
                    end else begin
                        bad_d = bad_now;
                        if (field_final) begin
                            state_d = (state_q == LOAD_R1) ? LOAD_R2 : LOAD_R4;
                        end
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                upd_d   = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                state_d = LOAD_R1;
            end
            DRAIN: begin
                if (accept && wr_last) begin
                    state_d = LOAD_R1;
                end
            end
            default: state_d = LOAD_R1;
        endcase
    end

    always_comb begin
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        sh4_d = sh4_q;
        if (accept) begin
            case (state_q)
                LOAD_R1: sh1_d[lane]     = wr_data[EW-1:0];
                LOAD_R2: sh2_d[row][col] = wr_data[0];
                LOAD_R4: sh4_d[p0][p1]   = wr_data[P2-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        reg1_d = reg1_q;
        reg2_d = reg2_q;
        reg4_d = reg4_q;
        if (commit) begin
            reg1_d = sh1_q;
            reg2_d = sh2_q;
            reg4_d = sh4_q;
        end
    end

    // Shadow contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        sh1_q <= sh1_d;
        sh2_q <= sh2_d;
        sh4_q <= sh4_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_R1;
            bad_q   <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            reg1_q  <= '{default: '0};
            reg2_q  <= '{default: '0};
            reg4_q  <= '0;
        end else begin
            state_q <= state_d;
            bad_q   <= bad_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            reg4_q  <= reg4_d;
        end
    end

    assign reg1      = reg1_q;
    assign reg2      = reg2_q;
    assign reg4      = reg4_q;
    assign upd       = upd_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_array_frame_driver.sv
// ============================================================================
// Module      : tb_array_frame_driver
// Description : Directed self-checking bench for array_frame_driver
//               (parity scenario built when ARRAY_DRV_PARITY_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_frame_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [2:0]              wr_data;
    logic                    wr_last;
`ifdef ARRAY_DRV_PARITY_EN
    logic                    wr_par;
`endif
    logic [1:0]              reg1 [4];
    logic                    reg2 [5][6];
    logic [1:0][3:0][2:0]    reg4;
    logic                    upd;
    logic                    frame_err;
    logic [15:0]             frame_cnt;

    int checks    = 0;
    int errors    = 0;
    int err_seen  = 0;
    int upd_seen  = 0;
    int nrdy_seen = 0;

    array_frame_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
`ifdef ARRAY_DRV_PARITY_EN
        .wr_par    (wr_par),
`endif
        .reg1      (reg1),
        .reg2      (reg2),
        .reg4      (reg4),
        .upd       (upd),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (upd === 1'b1) upd_seen++;
        if (rst_n === 1'b1 && wr_ready === 1'b0) nrdy_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat payload model: pat=0 is the reference frame, pat=1 its inverse.
    function automatic logic [2:0] beat_val(input int i, input bit pat);
        int k;
        logic [2:0] v;
        if (i < 4) begin
            v = 3'(i) ^ (pat ? 3'd3 : 3'd0);
        end else if (i < 34) begin
            k = i - 4;
            v = 3'(((k / 6) + (k % 6)) & 1) ^ (pat ? 3'd1 : 3'd0);
        end else if (i < 42) begin
            k = i - 34;
            v = 3'((k / 4) * 4 + (k % 4)) ^ (pat ? 3'd7 : 3'd0);
        end else begin
            v = 3'(i & 7);
        end
        return v;
    endfunction

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [2:0] d, input logic l, input bit flip);
        bit ok;
        int guard;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
`ifdef ARRAY_DRV_PARITY_EN
        wr_par   = (^d) ^ flip;
`endif
        ok    = 1'b0;
        guard = 0;
        while (!ok && guard < 20) begin
            @(negedge clk);
            ok = (wr_ready === 1'b1);
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) chk("beat_accept_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int last_at, input bit pat,
                              input bit gaps, input int flip_at);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            beat(beat_val(i, pat), (i + 1 == last_at), (i + 1 == flip_at));
        end
    endtask

    task automatic check_out(input string tag, input bit pat);
        for (int l = 0; l < 4; l++)
            chk($sformatf("%s_reg1_%0d", tag, l), reg1[l], (l ^ (pat ? 3 : 0)) & 3);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++)
                chk($sformatf("%s_reg2_%0d_%0d", tag, r, c), reg2[r][c], ((r + c) & 1) ^ (pat ? 1 : 0));
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 4; b++)
                chk($sformatf("%s_reg4_%0d_%0d", tag, a, b), reg4[a][b], (a * 4 + b) ^ (pat ? 7 : 0));
    endtask

    task automatic check_zero(input string tag);
        for (int l = 0; l < 4; l++)
            chk($sformatf("%s_reg1_%0d", tag, l), reg1[l], 0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++)
                chk($sformatf("%s_reg2_%0d_%0d", tag, r, c), reg2[r][c], 0);
        chk({tag, "_reg4"}, reg4, 0);
        chk({tag, "_upd"}, upd, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Entered one step after the edge that accepted the last beat (COMMIT cycle).
    task automatic finish_commit(input string tag, input bit pat, input int cnt);
        @(negedge clk);
        chk({tag, "_ready_in_commit"}, wr_ready, 0);
        chk({tag, "_upd_early"}, upd, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_upd_pulse"}, upd, 1);
        chk({tag, "_frame_cnt"}, frame_cnt, cnt);
        chk({tag, "_ready_after"}, wr_ready, 1);
        check_out(tag, pat);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_upd_single"}, upd, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        err_seen  = 0;
        upd_seen  = 0;
        nrdy_seen = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
`ifdef ARRAY_DRV_PARITY_EN
        wr_par   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", wr_ready, 1);

        clear_seen();
        send_frame(42, 42, 1'b0, 1'b0, 0);
        finish_commit("full", 1'b0, 1);
        chk("full_nready_cycles", nrdy_seen, 1);
        chk("full_no_err", err_seen, 0);

        clear_seen();
        send_frame(42, 42, 1'b1, 1'b1, 0);
        finish_commit("gap_inv", 1'b1, 2);
        chk("gap_inv_nready_cycles", nrdy_seen, 1);

        clear_seen();
        send_frame(42, 42, 1'b0, 1'b1, 0);
        finish_commit("gap_ref", 1'b0, 3);
        chk("gap_ref_nready_cycles", nrdy_seen, 1);

        clear_seen();
        send_frame(10, 10, 1'b1, 1'b0, 0);
        idle(3);
        chk("early_err_pulses", err_seen, 1);
        chk("early_no_upd", upd_seen, 0);
        chk("early_no_stall", nrdy_seen, 0);
        chk("early_frame_cnt", frame_cnt, 3);
        check_out("early_hold", 1'b0);
        send_frame(42, 42, 1'b1, 1'b0, 0);
        finish_commit("after_early", 1'b1, 4);

        clear_seen();
        send_frame(50, 50, 1'b0, 1'b0, 0);
        idle(3);
        chk("missing_err_pulses", err_seen, 1);
        chk("missing_no_upd", upd_seen, 0);
        chk("missing_frame_cnt", frame_cnt, 4);
        check_out("missing_hold", 1'b1);
        send_frame(42, 42, 1'b0, 1'b0, 0);
        finish_commit("after_drain", 1'b0, 5);

`ifdef ARRAY_DRV_PARITY_EN
        clear_seen();
        send_frame(42, 42, 1'b1, 1'b0, 20);
        idle(3);
        chk("parity_err_pulses", err_seen, 1);
        chk("parity_no_upd", upd_seen, 0);
        chk("parity_frame_cnt", frame_cnt, 5);
        check_out("parity_hold", 1'b0);
        send_frame(42, 42, 1'b1, 1'b0, 0);
        finish_commit("parity_good", 1'b1, 6);
`endif

        send_frame(20, 0, 1'b1, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrun_ready", wr_ready, 1);
        send_frame(42, 42, 1'b1, 1'b0, 0);
        finish_commit("post_reset", 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
